// File: rtl/ysyx_24080006_mdu_ctrl.sv
// rtl/ysyx_24080006_mdu_ctrl.sv - iterative RV32M multiply/divide sequencer
// Borrows the EX-stage ALU adder through mdu_enable; sign fix-up around 32 shift-add/sub steps.
module ysyx_24080006_mdu_ctrl #(
   parameter int XLEN  = 32,
   parameter int ITERS = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      in_op,
   input  logic [XLEN-1:0] in_a,
   input  logic [XLEN-1:0] in_b,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_result,
   output logic            mdu_enable,
   output logic [XLEN:0]   mdu_a,
   output logic [XLEN:0]   mdu_b,
   input  logic [XLEN+1:0] add_res
);

   localparam int CW = $clog2(ITERS);
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [2:0] {IDLE, NEG_A, NEG_B, ITER, NEG_LO, NEG_HI, DONE} state_t;

   state_t          state, state_nx;
   logic [2:0]      op;
   logic [XLEN-1:0] a, b, hi, lo;
   logic            sa, sb, bl;
   logic [CW-1:0]   cnt;

   logic            carry;
   logic [XLEN-1:0] sum;
   logic            unused_add_lsb;
   assign carry          = add_res[XLEN+1];
   assign sum            = add_res[XLEN:1];
   assign unused_add_lsb = add_res[0];

   assign in_ready = (state == IDLE);

   logic            accept, in_a_sgn, in_b_sgn, div_by_zero, div_ovf, fast;
   logic [XLEN-1:0] fast_res;
   assign accept      = in_valid & in_ready & ~flush;
   assign in_a_sgn    = in_op[2] ? ~in_op[0] : (in_op != 3'd3);
   assign in_b_sgn    = in_op[2] ? ~in_op[0] : ~in_op[1];
   assign div_by_zero = in_op[2] & (in_b == '0);
   assign div_ovf     = in_op[2] & ~in_op[0] & (in_a == MIN_NEG) & (in_b == '1);
   assign fast        = div_by_zero | div_ovf;
   assign fast_res    = div_by_zero ? (in_op[1] ? in_a : '1) : (in_op[1] ? '0 : MIN_NEG);

   logic            is_mul, is_div_s, is_rem, neg, neg_lo, neg_hi, hi_res, qbit, c_hi;
   logic [XLEN-1:0] div_r;
   assign is_mul   = ~op[2];
   assign is_div_s = (op == 3'd4);
   assign is_rem   = op[2] & op[1];
   assign neg      = (is_mul | is_div_s) ? (sa ^ sb) : sa;
   assign neg_lo   = neg & (is_mul | is_div_s);
   assign neg_hi   = neg & (is_mul | is_rem);
   assign hi_res   = is_mul ? (op != 3'd0) : is_rem;
   assign div_r    = {hi[XLEN-2:0], lo[XLEN-1]};
   // hi[XLEN-1] set means the shifted remainder exceeds XLEN bits, so it always beats b
   assign qbit     = hi[XLEN-1] | carry;
   assign c_hi     = is_mul ? bl : 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx   = state;
      mdu_enable = 1'b0;
      mdu_a      = '0;
      mdu_b      = '0;
      case (state)
         IDLE: if (accept) state_nx = fast ? DONE : NEG_A;
         NEG_A: begin
            mdu_enable = 1'b1;
            mdu_a      = {{XLEN{1'b0}}, 1'b1};
            mdu_b      = {~a, 1'b1};
            state_nx   = NEG_B;
         end
         NEG_B: begin
            mdu_enable = 1'b1;
            mdu_a      = {{XLEN{1'b0}}, 1'b1};
            mdu_b      = {~b, 1'b1};
            state_nx   = ITER;
         end
         ITER: begin
            mdu_enable = 1'b1;
            if (is_mul) begin
               mdu_a = {hi, 1'b0};
               mdu_b = lo[0] ? {b, 1'b0} : '0;
            end else begin
               mdu_a = {div_r, 1'b1};
               mdu_b = {~b, 1'b1};
            end
            if (cnt == CW'(ITERS - 1)) state_nx = NEG_LO;
         end
         NEG_LO: begin
            mdu_enable = 1'b1;
            mdu_a      = {{XLEN{1'b0}}, 1'b1};
            mdu_b      = {~lo, 1'b1};
            state_nx   = NEG_HI;
         end
         NEG_HI: begin
            mdu_enable = 1'b1;
            mdu_a      = {~hi, c_hi};
            mdu_b      = {{XLEN{1'b0}}, c_hi};
            state_nx   = DONE;
         end
         DONE: if (out_valid && out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
      if (flush && state != IDLE) state_nx = IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op         <= '0;
         a          <= '0;
         b          <= '0;
         hi         <= '0;
         lo         <= '0;
         sa         <= 1'b0;
         sb         <= 1'b0;
         bl         <= 1'b0;
         cnt        <= '0;
         out_valid  <= 1'b0;
         out_result <= '0;
      end else if (flush && state != IDLE) begin
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               op  <= in_op;
               a   <= in_a;
               b   <= in_b;
               sa  <= in_a_sgn & in_a[XLEN-1];
               sb  <= in_b_sgn & in_b[XLEN-1];
               cnt <= '0;
               if (fast) begin
                  out_valid  <= 1'b1;
                  out_result <= fast_res;
               end
            end
            NEG_A: if (sa) a <= sum;
            NEG_B: begin
               if (sb) b <= sum;
               lo  <= a;
               hi  <= '0;
               cnt <= '0;
            end
            ITER: begin
               cnt <= cnt + 1'b1;
               if (is_mul) {hi, lo} <= {carry, sum, lo[XLEN-1:1]};
               else begin
                  hi <= qbit ? sum : div_r;
                  lo <= {lo[XLEN-2:0], qbit};
               end
            end
            NEG_LO: begin
               bl <= carry;
               if (neg_lo) lo <= sum;
            end
            NEG_HI: begin
               if (neg_hi) hi <= sum;
               out_valid  <= 1'b1;
               out_result <= hi_res ? (neg_hi ? sum : hi) : lo;
            end
            DONE: if (out_valid && out_ready) out_valid <= 1'b0;
            default: ;
         endcase
      end
   end

endmodule

// File: doc/ysyx_24080006_mdu_ctrl.md
Name: ysyx_24080006_mdu_ctrl

Overview:
Iterative RV32M multiply/divide sequencer. It borrows the EX-stage ALU's 33-bit adder through the mdu_enable override, so it has no wide adder of its own.
It accepts one op per valid/ready handshake from EX and sequences sign fix-up and 32 shift-add or shift-subtract iterations. It returns a 32-bit result on a valid/ready output. The ALU is unavailable to EX while mdu_enable=1.

Parameters:
XLEN, 32, operand and result width; only 32 is supported.
ITERS, 32, iteration count; must equal XLEN.

Ports:
clk  in  1  clock
rst_n  in  1  reset
in_valid  in  1  op request
in_ready  out  1  ctrl idle, can accept
in_op  in  3  funct3 order: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
in_a  in  32  rs1 value
in_b  in  32  rs2 value
flush  in  1  abort current op
out_valid  out  1  result ready
out_ready  in  1  consumer accepts
out_result  out  32  result
mdu_enable  out  1  ALU adder override
mdu_a  out  33  adder operand A
mdu_b  out  33  adder operand B
add_res  in  34  ALU adder sum; carry = add_res[33], value = add_res[32:1]

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset state: state=IDLE; out_valid=0; out_result=0; mdu_enable=0; mdu_a=0; mdu_b=0; all internal registers 0.
- in_ready = (state==IDLE), combinational.
- Adder conventions:
  - X+Y: A={X,0}, B={Y,0}.
  - X-Y: A={X,1}, B={~Y,1}.
  - mdu_a and mdu_b are combinational from state and registers. Both are 0 when mdu_enable=0.
- States: IDLE, NEG_A, NEG_B, ITER, NEG_LO, NEG_HI, DONE.
- mdu_enable=1 exactly in NEG_A, NEG_B, ITER, NEG_LO and NEG_HI.
- IDLE, on in_valid & in_ready:
  - Latch op, a, b, sa = signed-op & a[31], sb = signed-op & b[31].
  - Signedness: a is signed for MUL, MULH, MULHSU, DIV, REM. b is signed for MUL, MULH, DIV, REM.
  - Fast path, any div op with b==0: result = all ones for DIV/DIVU, a for REM/REMU. Go to DONE.
  - Fast path, DIV/REM with a=0x80000000 and b=0xFFFFFFFF: result = 0x80000000 for DIV, 0 for REM. Go to DONE.
  - Otherwise go to NEG_A.
- NEG_A: if sa, a ← 0-a. NEG_B: if sb, b ← 0-b. Both use the shared adder and always take 1 cycle.
- ITER, 32 cycles, cnt 0..31:
  - Multiply: lo=a (multiplier), hi=0 initially. If lo[0], {c,s}=hi+b; else c=0, s=hi. Then {hi,lo} ← {c,s,lo[31:1]}.
  - Divide: lo=a (dividend), hi=0 initially. r={hi[30:0],lo[31]}, trial=r-b. qbit = hi[31] | carry. hi ← qbit ? trial : r; lo ← {lo[30:0],qbit}.
- NEG_LO and NEG_HI:
  - neg = mul ? sa^sb : (DIV ? sa^sb : sa).
  - NEG_LO: if neg and (mul or DIV), lo ← 0-lo; borrow bl = carry.
  - NEG_HI: if neg and (mul or REM), hi ← ~hi + c, with c = mul ? bl : 1. Adder drive: A={~hi,c}, B={0,c}.
  - Both states always take 1 cycle each.
- Result selection: MUL → lo; MULH/MULHSU/MULHU → hi; DIV/DIVU → lo; REM/REMU → hi.
- Timing:
  - Fast path: out_valid 1 edge after accept.
  - Normal path: fixed, out_valid asserts 37 edges after the accept edge.
- DONE: out_valid=1 and out_result held stable until out_valid & out_ready, then go to IDLE. A new op can be accepted no earlier than the cycle after.
- flush:
  - In any non-IDLE state, the next edge goes to IDLE with out_valid=0 and mdu_enable=0. No result is produced.
  - flush overrides out_ready in DONE.
  - flush in IDLE blocks accept that cycle.
- in_valid is ignored while not IDLE. Operands are latched, so in_a and in_b may change after accept.
- Async reset mid-op: immediate return to reset values with no partial result.

Test Plan:
- MUL 7 × 0xFFFFFFFD → 0xFFFFFFEB, out_valid 37 edges after accept. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULH 0x80000000 × 0x80000000 → 0x40000000. MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD. REM same operands → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2. DIVU 0xFFFFFFFF/1 → 0xFFFFFFFF.
- Fast paths, out_valid 1 edge after accept, mdu_enable never high: DIV 5/0 → 0xFFFFFFFF; REMU 5/0 → 5; DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM same operands → 0.
- Backpressure: out_ready=0 for 10 cycles in DONE → out_result stable, in_ready=0. out_ready=1 → IDLE next edge, and a back-to-back op is then accepted.
- flush asserted at ITER cnt=10 → IDLE next edge, mdu_enable=0, no out_valid. A subsequent MUL 3×4 → 12.
- rst_n low mid-ITER, asynchronously → out_valid, mdu_enable, mdu_a and mdu_b are 0 immediately. After release, in_ready=1.
